// File: rtl/bp_ctrl_if.sv
// Fetch/decode-side signal bundle for the branch predictor controller.
// The pipeline side uses the master modport and bp_ctrl uses the slave modport.
// Optional: BP_STATS_EN adds the stat_br/stat_miss counter outputs.
interface bp_ctrl_if;
    logic        stall;
    logic        flush_exc;
    logic [31:0] PC_F;
    logic        BP_WR;
    logic [31:0] PC_BP;
    logic [31:0] PC_D;
    logic        br_D;
    logic        taken_D;
    logic [31:0] target_D;
    logic        mispred;
    logic [31:0] PC_FIX;
    logic        pred_D;
`ifdef BP_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_miss;
`endif

`ifdef BP_STATS_EN
    modport master (
        output stall, flush_exc, PC_F, PC_D, br_D, taken_D, target_D,
        input  BP_WR, PC_BP, mispred, PC_FIX, pred_D, stat_br, stat_miss
    );
    modport slave (
        input  stall, flush_exc, PC_F, PC_D, br_D, taken_D, target_D,
        output BP_WR, PC_BP, mispred, PC_FIX, pred_D, stat_br, stat_miss
    );
`else
    modport master (
        output stall, flush_exc, PC_F, PC_D, br_D, taken_D, target_D,
        input  BP_WR, PC_BP, mispred, PC_FIX, pred_D
    );
    modport slave (
        input  stall, flush_exc, PC_F, PC_D, br_D, taken_D, target_D,
        output BP_WR, PC_BP, mispred, PC_FIX, pred_D
    );
`endif
endinterface

// File: rtl/bp_ctrl.sv
// Dynamic branch predictor and mispredict-recovery controller.
// A direct-mapped BTB with 2-bit counters is looked up with the F-stage PC.
// The prediction follows the instruction into D, where it is checked against
// the actual resolution, and the table is trained there.
// Optional: BP_STATS_EN adds stat_br/stat_miss event counters.
module bp_ctrl #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    bp_ctrl_if.slave bp
);
    localparam int N = 2 ** IDX_W;

    logic              valid_q [N];
    logic [TAG_W-1:0]  tag_q   [N];
    logic [31:0]       tgt_q   [N];
    logic [1:0]        ctr_q   [N];

    logic              pend_taken_q, pend_taken_d;
    logic [31:0]       pend_target_q, pend_target_d;

    logic [IDX_W-1:0]  idx_f, idx_d;
    logic [TAG_W-1:0]  tag_f, tag_d;
    logic              hit_f, hit_d;
    logic              active;
    logic              upd;
    logic              alias_clr;
    logic              mispred;
    logic              bp_wr;

    assign idx_f = bp.PC_F[IDX_W+1:2];
    assign tag_f = bp.PC_F[IDX_W+TAG_W+1:IDX_W+2];
    assign idx_d = bp.PC_D[IDX_W+1:2];
    assign tag_d = bp.PC_D[IDX_W+TAG_W+1:IDX_W+2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.PC_F[1:0], bp.PC_F[31:IDX_W+TAG_W+2],
                              bp.PC_D[1:0], bp.PC_D[31:IDX_W+TAG_W+2]};

    // Lookup and D-stage check are purely combinational from registered state.
    always_comb begin
        hit_f     = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        hit_d     = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
        bp_wr     = hit_f && ctr_q[idx_f][1];
        active    = !bp.stall && !bp.flush_exc;
        upd       = bp.br_D && active;
        alias_clr = !bp.br_D && pend_taken_q && active;
        mispred   = 1'b0;
        if (active) begin
            if (bp.br_D)
                mispred = (bp.taken_D != pend_taken_q) ||
                          (bp.taken_D && pend_taken_q && (bp.target_D != pend_target_q));
            else
                mispred = pend_taken_q;
        end
    end

    assign bp.BP_WR   = bp_wr;
    assign bp.PC_BP   = bp_wr ? tgt_q[idx_f] : 32'd0;
    assign bp.mispred = mispred;
    assign bp.PC_FIX  = (bp.br_D && bp.taken_D) ? bp.target_D : bp.PC_D + 32'd4;
    assign bp.pred_D  = pend_taken_q;

    // Next value of the prediction carried into D; squash beats the normal advance.
    always_comb begin
        pend_taken_d  = pend_taken_q;
        pend_target_d = pend_target_q;
        if (bp.flush_exc || mispred) begin
            pend_taken_d  = 1'b0;
            pend_target_d = 32'd0;
        end else if (!bp.stall) begin
            pend_taken_d  = bp_wr;
            pend_target_d = bp.PC_BP;
        end
    end

    // Pending prediction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_taken_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            pend_taken_q  <= pend_taken_d;
            pend_target_q <= pend_target_d;
        end
    end

    // BTB training at D-stage resolution; only valid bits need reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) valid_q[i] <= 1'b0;
        end else if (upd) begin
            if (hit_d) begin
                if (bp.taken_D) begin
                    if (ctr_q[idx_d] != 2'd3) ctr_q[idx_d] <= ctr_q[idx_d] + 2'd1;
                    tgt_q[idx_d] <= bp.target_D;
                end else if (ctr_q[idx_d] != 2'd0) begin
                    ctr_q[idx_d] <= ctr_q[idx_d] - 2'd1;
                end
            end else if (bp.taken_D) begin
                valid_q[idx_d] <= 1'b1;
                tag_q[idx_d]   <= tag_d;
                tgt_q[idx_d]   <= bp.target_D;
                ctr_q[idx_d]   <= 2'b10;
            end
        end else if (alias_clr) begin
            valid_q[idx_d] <= 1'b0;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_miss_q;

    // Event counters, wrapping naturally at 2**32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q   <= 32'd0;
            stat_miss_q <= 32'd0;
        end else begin
            if (upd)     stat_br_q   <= stat_br_q + 32'd1;
            if (mispred) stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign bp.stat_br   = stat_br_q;
    assign bp.stat_miss = stat_miss_q;
`endif
endmodule

// File: tb/tb_bp_ctrl.sv
// Directed testbench for bp_ctrl with hand-computed expectations.
module tb_bp_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    bp_ctrl_if bp();

    bp_ctrl dut (.clk(clk), .reset(reset), .bp(bp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs checked 1 time unit later, well away from any edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stl, input logic fl, input logic [31:0] pcf,
                         input logic [31:0] pcd, input logic br, input logic tk,
                         input logic [31:0] tgt);
        bp.stall     = stl;
        bp.flush_exc = fl;
        bp.PC_F      = pcf;
        bp.PC_D      = pcd;
        bp.br_D      = br;
        bp.taken_D   = tk;
        bp.target_D  = tgt;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        bp.stall = 0; bp.flush_exc = 0; bp.PC_F = 0; bp.PC_D = 0;
        bp.br_D = 0; bp.taken_D = 0; bp.target_D = 0;
        tick; tick;
        reset = 1'b0;

        // Reset state
        tick;
        drive(0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
        check("rst_bp_wr",   bp.BP_WR, 0);
        check("rst_pc_bp",   bp.PC_BP, 0);
        check("rst_mispred", bp.mispred, 0);
        check("rst_pred_d",  bp.pred_D, 0);
        check("rst_pc_fix",  bp.PC_FIX, 32'h4);
        drive(0, 0, 32'hBFC0_0000, 32'h0000_0000, 0, 0, 0);
        check("boot_bp_wr", bp.BP_WR, 0);
        check("boot_pc_bp", bp.PC_BP, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            drive(0, 0, 32'hBFC0_0000 + 32'(4 * i), 32'hBFC0_0000, 0, 0, 0);
            check("boot_no_mispred", bp.mispred, 0);
        end

        // Cold taken branch -> mispredict and allocate (ctr=2)
        tick;
        drive(0, 0, 32'hBFC0_0010, 32'h0040_0010, 1, 1, 32'h0040_0100);
        check("cold_mispred", bp.mispred, 1);
        check("cold_pc_fix",  bp.PC_FIX, 32'h0040_0100);
        tick;
        drive(0, 0, 32'h0040_0010, 32'hBFC0_0014, 0, 0, 0);
        check("alloc_bp_wr", bp.BP_WR, 1);
        check("alloc_pc_bp", bp.PC_BP, 32'h0040_0100);
        check("alloc_no_mispred", bp.mispred, 0);

        // Taken twice more (ctr 3, 3), correctly predicted
        for (int i = 0; i < 2; i++) begin
            tick;
            drive(0, 0, 32'h0040_0010, 32'h0040_0010, 1, 1, 32'h0040_0100);
            check("train_pred_d",  bp.pred_D, 1);
            check("train_mispred", bp.mispred, 0);
        end
        // Not taken -> mispredict, ctr 2
        tick;
        drive(0, 0, 32'h0000_0000, 32'h0040_0010, 1, 0, 32'h0);
        check("nt_mispred", bp.mispred, 1);
        check("nt_pc_fix",  bp.PC_FIX, 32'h0040_0014);
        tick;
        drive(0, 0, 32'h0040_0010, 32'h0040_0014, 0, 0, 0);
        check("nt_still_taken", bp.BP_WR, 1);
        check("nt_pred_cleared", bp.pred_D, 0);

        // Predicted taken but target differs
        tick;
        drive(0, 0, 32'h0000_0000, 32'h0040_0010, 1, 1, 32'h0040_0200);
        check("tgt_mispred", bp.mispred, 1);
        check("tgt_pc_fix",  bp.PC_FIX, 32'h0040_0200);
        tick;
        drive(0, 0, 32'h0040_0010, 32'h0040_0200, 0, 0, 0);
        check("tgt_updated", bp.PC_BP, 32'h0040_0200);

        // Stall during a mispredicting resolution (ctr 3 after retarget)
        tick;
        drive(1, 0, 32'h0040_0010, 32'h0040_0010, 1, 0, 0);
        check("stall_no_mispred", bp.mispred, 0);
        tick;
        drive(0, 0, 32'h0040_0010, 32'h0040_0010, 1, 0, 0);
        check("unstall_pred_held", bp.pred_D, 1);
        check("unstall_mispred", bp.mispred, 1);
        check("unstall_pc_fix",  bp.PC_FIX, 32'h0040_0014);
        tick;
        drive(0, 0, 32'h0040_0010, 32'h0040_0014, 0, 0, 0);
        check("mispred_once", bp.mispred, 0);

        // Flush during a mispredicting resolution: no mispred, no training
        tick;
        drive(0, 1, 32'h0040_0010, 32'h0040_0010, 1, 0, 0);
        check("flush_no_mispred", bp.mispred, 0);
        tick;
        drive(0, 0, 32'h0080_0010, 32'h8000_0180, 0, 0, 0);
        check("flush_pred_cleared", bp.pred_D, 0);
        check("alias_fetch_bp_wr",  bp.BP_WR, 1);
        check("alias_fetch_pc_bp",  bp.PC_BP, 32'h0040_0200);

        // Alias: non-branch predicted taken reaches D
        tick;
        drive(0, 0, 32'h0000_0000, 32'h0080_0010, 0, 0, 0);
        check("alias_mispred", bp.mispred, 1);
        check("alias_pc_fix",  bp.PC_FIX, 32'h0080_0014);
        tick;
        drive(0, 0, 32'h0040_0010, 32'h0080_0014, 0, 0, 0);
        check("alias_invalidated", bp.BP_WR, 0);
        check("alias_inval_pc_bp", bp.PC_BP, 0);

        // PC_FIX wrap
        drive(0, 0, 32'h0000_0000, 32'hFFFF_FFFC, 0, 0, 0);
        check("fix_wrap", bp.PC_FIX, 32'h0);

        // Reallocate, then reset mid-operation discards table and pending state
        tick;
        drive(0, 0, 32'h0000_0000, 32'h0040_0030, 1, 1, 32'h0040_0400);
        check("realloc_mispred", bp.mispred, 1);
        tick;
        drive(0, 0, 32'h0040_0030, 32'h0000_0000, 0, 0, 0);
        check("realloc_bp_wr", bp.BP_WR, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive(0, 0, 32'h0040_0030, 32'h0000_0000, 0, 0, 0);
        check("midrst_bp_wr",  bp.BP_WR, 0);
        check("midrst_pred_d", bp.pred_D, 0);

`ifdef BP_STATS_EN
        check("stats_rst_br",   bp.stat_br, 0);
        check("stats_rst_miss", bp.stat_miss, 0);
        drive(0, 0, 32'h0, 32'h0040_0050, 1, 1, 32'h0040_0500);
        tick;
        drive(0, 0, 32'h0, 32'h0040_0054, 0, 0, 0);
        check("stats_br",   bp.stat_br, 1);
        check("stats_miss", bp.stat_miss, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
